// File: rtl/order_arbiter.sv
// Round-robin order arbiter with a windowed rate limit and a one-cycle registered
// output stage carrying the granted order word to the formatter.
module order_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ORDER_W = 64,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ORDER_W-1:0] req_order,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       cfg_enable,
  input  logic [NUM_REQ-1:0]         cfg_mask,
  input  logic [7:0]                 cfg_max_per_window,
  input  logic [15:0]                cfg_window_len,
  output logic [ORDER_W-1:0]         approved_order,
  output logic                       approved_valid,
  output logic [SRC_W-1:0]           approved_src,
  output logic                       throttled,
  output logic [31:0]                total_issued
);

  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [15:0]        wcnt_q, wcnt_d;
  logic [7:0]         icnt_q, icnt_d;
  logic [31:0]        total_q, total_d;
  logic [ORDER_W-1:0] ord_q, ord_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic               vld_q, vld_d;

  logic [NUM_REQ-1:0] eligible;
  logic [SRC_W-1:0]   gnt_idx;
  logic               found;
  logic               grant;
  logic               thr_en;
  logic               thr;
  logic               wrap;

  // Throttle compares with >= so lowering the limit below the running count bites at once.
  assign thr_en = (cfg_max_per_window != 8'd0) && (cfg_window_len != 16'd0);
  assign thr    = thr_en && (icnt_q >= cfg_max_per_window);
  assign wrap   = wcnt_q >= (cfg_window_len - 16'd1);

  assign eligible = req_valid & ~cfg_mask;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && eligible[ptr_q + SRC_W'(i)]) begin
        found   = 1'b1;
        gnt_idx = ptr_q + SRC_W'(i);
      end
    end
  end

  assign grant     = !reset && cfg_enable && !thr && found;
  assign req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    ptr_d   = ptr_q;
    total_d = total_q;
    ord_d   = ord_q;
    src_d   = src_q;
    vld_d   = grant;
    if (grant) begin
      ptr_d   = gnt_idx + SRC_W'(1);
      total_d = total_q + 32'd1;
      ord_d   = req_order[gnt_idx*ORDER_W +: ORDER_W];
      src_d   = gnt_idx;
    end
  end

  // A grant landing on the wrap cycle is the first of the new window.
  always_comb begin
    wcnt_d = '0;
    icnt_d = '0;
    if (thr_en) begin
      if (wrap) begin
        wcnt_d = '0;
        icnt_d = grant ? 8'd1 : 8'd0;
      end else begin
        wcnt_d = wcnt_q + 16'd1;
        icnt_d = icnt_q + (grant ? 8'd1 : 8'd0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      wcnt_q  <= '0;
      icnt_q  <= '0;
      total_q <= '0;
      ord_q   <= '0;
      src_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      icnt_q  <= icnt_d;
      total_q <= total_d;
      ord_q   <= ord_d;
      src_q   <= src_d;
      vld_q   <= vld_d;
    end
  end

  assign approved_order = ord_q;
  assign approved_valid = vld_q;
  assign approved_src   = src_q;
  assign throttled      = thr;
  assign total_issued   = total_q;

endmodule

// File: tb/tb_order_arbiter.sv
// Directed bench for order_arbiter: round-robin order, masking, rate limit,
// enable gating, reset mid-stream and total_issued wrap.
module tb_order_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [255:0] req_order;
  logic [3:0]   req_ready;
  logic         cfg_enable;
  logic [3:0]   cfg_mask;
  logic [7:0]   cfg_max_per_window;
  logic [15:0]  cfg_window_len;
  logic [63:0]  approved_order;
  logic         approved_valid;
  logic [1:0]   approved_src;
  logic         throttled;
  logic [31:0]  total_issued;

  int n_chk = 0;
  int n_err = 0;

  order_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_order(req_order),
    .req_ready(req_ready), .cfg_enable(cfg_enable), .cfg_mask(cfg_mask),
    .cfg_max_per_window(cfg_max_per_window), .cfg_window_len(cfg_window_len),
    .approved_order(approved_order), .approved_valid(approved_valid),
    .approved_src(approved_src), .throttled(throttled), .total_issued(total_issued)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ord(input int i);
    logic [63:0] base;
    base = 64'hC0DE_0000_0000_0000;
    return base + 64'(i) * 64'h0000_0001_0000_0011;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 4'hF;
    req_order = '0;
    for (int i = 0; i < 4; i++) req_order[i*64 +: 64] = ord(i);
    cfg_enable = 1'b1;
    cfg_mask = 4'h0;
    cfg_max_per_window = 8'd0;
    cfg_window_len = 16'd0;
    step();
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_valid", 64'(approved_valid), 64'h0);
    chk("rst_order", approved_order, 64'h0);
    chk("rst_src", 64'(approved_src), 64'h0);
    chk("rst_thr", 64'(throttled), 64'h0);
    chk("rst_total", 64'(total_issued), 64'h0);

    // Single requester 2
    req_valid = 4'b0100;
    req_order[2*64 +: 64] = 64'hDEAD_BEEF_0000_0001;
    reset = 1'b0;
    #1;
    chk("r2_ready", 64'(req_ready), 64'h4);
    step();
    chk("r2_valid", 64'(approved_valid), 64'h1);
    chk("r2_order", approved_order, 64'hDEAD_BEEF_0000_0001);
    chk("r2_src", 64'(approved_src), 64'h2);
    chk("r2_total", 64'(total_issued), 64'h1);
    req_valid = 4'b0000;
    step();
    chk("idle_valid", 64'(approved_valid), 64'h0);
    chk("idle_order_hold", approved_order, 64'hDEAD_BEEF_0000_0001);
    chk("idle_src_hold", 64'(approved_src), 64'h2);
    req_order[2*64 +: 64] = ord(2);

    // All valid, rotation from pointer 0
    do_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      step();
      chk("rr_valid", 64'(approved_valid), 64'h1);
      chk("rr_src", 64'(approved_src), 64'(k % 4));
      chk("rr_order", approved_order, ord(k % 4));
    end
    chk("rr_total", 64'(total_issued), 64'd8);

    // Requester 0 masked
    cfg_mask = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("mask_ready", 64'(req_ready), 64'(4'b0010 << (k % 3)));
      step();
    end
    cfg_mask = 4'b0000;

    // Reset in the middle of continuous grants
    reset = 1'b1;
    #1;
    chk("midrst_valid", 64'(approved_valid), 64'h0);
    chk("midrst_total", 64'(total_issued), 64'h0);
    step();
    reset = 1'b0;
    #1;
    chk("postrst_ready", 64'(req_ready), 64'h1);
    step();
    chk("postrst_src", 64'(approved_src), 64'h0);
    chk("postrst_valid", 64'(approved_valid), 64'h1);

    // Rate limit: 3 per 10-cycle window
    reset = 1'b1;
    req_valid = 4'b0001;
    cfg_max_per_window = 8'd3;
    cfg_window_len = 16'd10;
    step();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk($sformatf("thr_ready_c%0d", c), 64'(req_ready),
          (c < 3 || c >= 10) ? 64'h1 : 64'h0);
      chk($sformatf("thr_flag_c%0d", c), 64'(throttled),
          (c >= 3 && c <= 9) ? 64'h1 : 64'h0);
      step();
    end
    // two grants in new window; lowering limit to 1 throttles at once
    cfg_max_per_window = 8'd1;
    #1;
    chk("lower_thr", 64'(throttled), 64'h1);
    chk("lower_ready", 64'(req_ready), 64'h0);
    cfg_max_per_window = 8'd0;
    #1;
    chk("unlim_thr", 64'(throttled), 64'h0);
    chk("unlim_ready", 64'(req_ready), 64'h1);
    step();

    // Enable drop is immediate; registered output still completes
    cfg_enable = 1'b0;
    #1;
    chk("dis_ready", 64'(req_ready), 64'h0);
    chk("dis_pending_valid", 64'(approved_valid), 64'h1);
    step();
    chk("dis_valid", 64'(approved_valid), 64'h0);

    // total_issued wrap
    force dut.total_q = 32'hFFFF_FFFF;
    #1;
    release dut.total_q;
    cfg_enable = 1'b1;
    #1;
    chk("wrap_pre", 64'(total_issued), 64'hFFFF_FFFF);
    step();
    chk("wrap_total", 64'(total_issued), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
